// File: rtl/block_reassembler.sv
// Block-to-raster reassembler: collects one block-row strip per bank (ping-pong)
// from the block-order pixel stream and drains it in image-raster order.
module block_reassembler #(
  parameter int unsigned DATA_DEPTH = 8,
  parameter int unsigned MAX_M      = 72,
  parameter int unsigned MAX_WIDTH  = 720
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic [7:0]            cfg_m,
  input  logic [7:0]            cfg_bpr,
  input  logic [7:0]            cfg_rows,
  output logic                  cfg_err,
  input  logic [DATA_DEPTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic [DATA_DEPTH-1:0] out_pixel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_overflow
);

  localparam int unsigned BANK_SIZE = MAX_M * MAX_WIDTH;
  localparam int unsigned ADDR_W    = $clog2(BANK_SIZE);
  localparam int unsigned W_W       = 10;
  localparam logic [15:0] MAX_M_L   = 16'(MAX_M);
  localparam logic [15:0] MAX_W_L   = 16'(MAX_WIDTH);

  typedef enum logic {W_IDLE, W_FILL} w_state_e;
  typedef enum logic {R_IDLE, R_DRAIN} r_state_e;

  logic [DATA_DEPTH-1:0] mem0 [BANK_SIZE];
  logic [DATA_DEPTH-1:0] mem1 [BANK_SIZE];

  // Configuration
  logic              configured_q, configured_d;
  logic [7:0]        m_q, m_d, bpr_q, bpr_d, rows_q, rows_d;
  logic [W_W-1:0]    w_q, w_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              cfg_err_q, cfg_err_d;

  // Write side
  w_state_e          w_state_q, w_state_d;
  logic [7:0]        c_q, c_d, r_q, r_d, bc_q, bc_d, br_q, br_d;
  logic [ADDR_W-1:0] addr_q, addr_d, row_q, row_d, blk_q, blk_d;
  logic              wr_bank_q, wr_bank_d;
  logic              err_ovf_q, err_ovf_d;

  // Bank status: full = holds data until drained, ready = full but not yet started
  logic [1:0]        full_q, full_d, ready_q, ready_d, last_strip_q, last_strip_d;

  // Read side
  r_state_e          r_state_q, r_state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic              out_bank_q, out_bank_d;
  logic [DATA_DEPTH-1:0] out_pixel_q;
  logic              frame_done_q, frame_done_d, busy_q, busy_d;

  logic [15:0]       cfg_w_c, cfg_cells_c;
  logic              cfg_ok_c, wr_en_c, frame_end_c, rd_issue_c, other_c;

  always_comb begin
    cfg_w_c     = 16'(cfg_m) * 16'(cfg_bpr);
    cfg_cells_c = 16'(cfg_m) * cfg_w_c;
    cfg_ok_c    = (cfg_m != 8'd0) && (cfg_bpr != 8'd0) && (cfg_rows != 8'd0) &&
                  (16'(cfg_m) <= MAX_M_L) && (cfg_w_c <= MAX_W_L);
  end

  always_comb begin
    configured_d = configured_q;
    m_d          = m_q;
    bpr_d        = bpr_q;
    rows_d       = rows_q;
    w_d          = w_q;
    last_d       = last_q;
    cfg_err_d    = cfg_err_q;
    w_state_d    = w_state_q;
    c_d          = c_q;
    r_d          = r_q;
    bc_d         = bc_q;
    br_d         = br_q;
    addr_d       = addr_q;
    row_d        = row_q;
    blk_d        = blk_q;
    wr_bank_d    = wr_bank_q;
    err_ovf_d    = err_ovf_q;
    full_d       = full_q;
    ready_d      = ready_q;
    last_strip_d = last_strip_q;
    r_state_d    = r_state_q;
    rd_bank_d    = rd_bank_q;
    rd_addr_d    = rd_addr_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_bank_d   = out_bank_q;
    frame_done_d = 1'b0;
    wr_en_c      = 1'b0;
    frame_end_c  = 1'b0;
    other_c      = ~rd_bank_q;
    rd_issue_c   = (r_state_q == R_DRAIN) && (!out_valid_q || out_ready);

    // Config is only taken between frames; a rejected one leaves the block unconfigured
    if (cfg_valid && !busy_q) begin
      if (cfg_ok_c) begin
        configured_d = 1'b1;
        m_d          = cfg_m;
        bpr_d        = cfg_bpr;
        rows_d       = cfg_rows;
        w_d          = W_W'(cfg_w_c);
        last_d       = ADDR_W'(cfg_cells_c - 16'd1);
        cfg_err_d    = 1'b0;
      end else begin
        configured_d = 1'b0;
        cfg_err_d    = 1'b1;
      end
    end

    // Write address r*W + bc*M + c tracked incrementally via row/block start offsets
    if (pix_valid && configured_q) begin
      if (full_q[wr_bank_q]) begin
        err_ovf_d = 1'b1;
      end else begin
        wr_en_c = 1'b1;
        if (c_q != m_q - 8'd1) begin
          c_d    = c_q + 8'd1;
          addr_d = addr_q + ADDR_W'(1);
        end else if (r_q != m_q - 8'd1) begin
          c_d    = 8'd0;
          r_d    = r_q + 8'd1;
          row_d  = row_q + ADDR_W'(w_q);
          addr_d = row_q + ADDR_W'(w_q);
        end else if (bc_q != bpr_q - 8'd1) begin
          c_d    = 8'd0;
          r_d    = 8'd0;
          bc_d   = bc_q + 8'd1;
          blk_d  = blk_q + ADDR_W'(m_q);
          row_d  = blk_q + ADDR_W'(m_q);
          addr_d = blk_q + ADDR_W'(m_q);
        end else begin
          c_d    = 8'd0;
          r_d    = 8'd0;
          bc_d   = 8'd0;
          blk_d  = '0;
          row_d  = '0;
          addr_d = '0;
          full_d[wr_bank_q]       = 1'b1;
          ready_d[wr_bank_q]      = 1'b1;
          last_strip_d[wr_bank_q] = (br_q == rows_q - 8'd1);
          wr_bank_d = ~wr_bank_q;
          if (br_q == rows_q - 8'd1) begin
            br_d        = 8'd0;
            frame_end_c = 1'b1;
          end else begin
            br_d = br_q + 8'd1;
          end
        end
      end
    end

    case (w_state_q)
      W_IDLE:  if (wr_en_c && !frame_end_c) w_state_d = W_FILL;
      W_FILL:  if (frame_end_c) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase

    // Drain banks in fill order; chain straight into the next strip if it is waiting
    case (r_state_q)
      R_IDLE: begin
        if (ready_q[rd_bank_q]) begin
          r_state_d          = R_DRAIN;
          rd_addr_d          = '0;
          ready_d[rd_bank_q] = 1'b0;
        end
      end
      R_DRAIN: begin
        if (rd_issue_c) begin
          if (rd_addr_q == last_q) begin
            rd_bank_d = other_c;
            rd_addr_d = '0;
            if (ready_q[other_c]) ready_d[other_c] = 1'b0;
            else                  r_state_d        = R_IDLE;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    if (rd_issue_c) begin
      out_valid_d = 1'b1;
      out_last_d  = (rd_addr_q == last_q);
      out_bank_d  = rd_bank_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Bank is released only once its final pixel has been handed off
    if (out_valid_q && out_ready && out_last_q) begin
      full_d[out_bank_q] = 1'b0;
      if (last_strip_q[out_bank_q]) frame_done_d = 1'b1;
    end

    busy_d = (w_state_d == W_FILL) || (full_d != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      configured_q <= 1'b0;
      m_q          <= '0;
      bpr_q        <= '0;
      rows_q       <= '0;
      w_q          <= '0;
      last_q       <= '0;
      cfg_err_q    <= 1'b0;
      w_state_q    <= W_IDLE;
      c_q          <= '0;
      r_q          <= '0;
      bc_q         <= '0;
      br_q         <= '0;
      addr_q       <= '0;
      row_q        <= '0;
      blk_q        <= '0;
      wr_bank_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
      full_q       <= '0;
      ready_q      <= '0;
      last_strip_q <= '0;
      r_state_q    <= R_IDLE;
      rd_bank_q    <= 1'b0;
      rd_addr_q    <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_bank_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      configured_q <= configured_d;
      m_q          <= m_d;
      bpr_q        <= bpr_d;
      rows_q       <= rows_d;
      w_q          <= w_d;
      last_q       <= last_d;
      cfg_err_q    <= cfg_err_d;
      w_state_q    <= w_state_d;
      c_q          <= c_d;
      r_q          <= r_d;
      bc_q         <= bc_d;
      br_q         <= br_d;
      addr_q       <= addr_d;
      row_q        <= row_d;
      blk_q        <= blk_d;
      wr_bank_q    <= wr_bank_d;
      err_ovf_q    <= err_ovf_d;
      full_q       <= full_d;
      ready_q      <= ready_d;
      last_strip_q <= last_strip_d;
      r_state_q    <= r_state_d;
      rd_bank_q    <= rd_bank_d;
      rd_addr_q    <= rd_addr_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_bank_q   <= out_bank_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      if (wr_bank_q) mem1[addr_q] <= pix_in;
      else           mem0[addr_q] <= pix_in;
    end
  end

  // Synchronous RAM read; this register is the output stage and holds under stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             out_pixel_q <= '0;
    else if (rd_issue_c) out_pixel_q <= rd_bank_q ? mem1[rd_addr_q] : mem0[rd_addr_q];
  end

  assign cfg_err      = cfg_err_q;
  assign out_pixel    = out_pixel_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_block_reassembler.sv
// Directed bench for block_reassembler: reassembly order, backpressure hold,
// overflow, config rejection/locking and asynchronous reset.
module tb_block_reassembler;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic [7:0] cfg_m, cfg_bpr, cfg_rows;
  logic       cfg_err;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic [7:0] out_pixel;
  logic       out_valid, out_ready, busy, frame_done, err_overflow;

  always #5 clk = ~clk;

  block_reassembler dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_m(cfg_m), .cfg_bpr(cfg_bpr),
    .cfg_rows(cfg_rows), .cfg_err(cfg_err), .pix_in(pix_in), .pix_valid(pix_valid),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .frame_done(frame_done), .err_overflow(err_overflow)
  );

  int         n_pass = 0;
  int         n_total = 0;
  int         got[$];
  int         exp_q[$];
  int         fd_cnt = 0;
  int         ready_mode = 1;
  logic       rdy_tog = 1'b0;
  logic       hold_chk = 1'b0;
  logic [7:0] held = '0;
  logic [7:0] cm = '0, cb = '0, cr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // One clock: drive inputs at the falling edge, record handshakes, check stall hold
  task automatic cyc(input logic pv, input int pd, input logic cv);
    @(negedge clk);
    pix_valid = pv;
    pix_in    = 8'(pd);
    cfg_valid = cv;
    cfg_m     = cm;
    cfg_bpr   = cb;
    cfg_rows  = cr;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: begin out_ready = rdy_tog; rdy_tog = ~rdy_tog; end
    endcase
    if (hold_chk) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_pixel", 32'(out_pixel), 32'(held));
    end
    if (out_valid && out_ready) got.push_back(int'(out_pixel));
    hold_chk = out_valid && !out_ready;
    held     = out_pixel;
    if (frame_done) begin
      fd_cnt++;
      chk("busy_at_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic feed(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, first + i, 1'b0);
      cyc(1'b0, 0, 1'b0);
    end
  endtask

  task automatic drain(input string tag, input int n);
    for (int k = 0; k < 2000 && !(got.size() >= n && fd_cnt > 0); k++) cyc(1'b0, 0, 1'b0);
    repeat (4) cyc(1'b0, 0, 1'b0);
    chk(tag, 32'(got.size()), 32'(n));
  endtask

  task automatic check_seq(input string tag);
    logic [31:0] g;
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF;
      chk(tag, g, 32'(exp_q[i]));
    end
  endtask

  task automatic send_cfg(input int m, input int bpr, input int rows);
    cm = 8'(m); cb = 8'(bpr); cr = 8'(rows);
    cyc(1'b0, 0, 1'b1);
    cyc(1'b0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_in = '0; cfg_valid = 1'b0; out_ready = 1'b0;
    cfg_m = '0; cfg_bpr = '0; cfg_rows = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pixel", 32'(out_pixel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_overflow", 32'(err_overflow), 32'd0);
    rst = 1'b0;

    // Basic 6x6 reassembly
    ready_mode = 1;
    send_cfg(3, 2, 2);
    chk("t1_cfg_err", 32'(cfg_err), 32'd0);
    got.delete(); fd_cnt = 0;
    for (int i = 0; i < 36; i++) begin
      cyc(1'b1, i, 1'b0);
      cyc(1'b0, 0, 1'b0);
      if (i == 1) chk("t1_busy", 32'(busy), 32'd1);
      if (i == 18) chk("t1_first_latency", 32'(got.size()), 32'd1);
    end
    drain("t1_count", 36);
    exp_q = {0,1,2,9,10,11, 3,4,5,12,13,14, 6,7,8,15,16,17,
             18,19,20,27,28,29, 21,22,23,30,31,32, 24,25,26,33,34,35};
    check_seq("t1_pix");
    chk("t1_frame_done", 32'(fd_cnt), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_overflow", 32'(err_overflow), 32'd0);

    // Backpressure: ready toggling, config retained from previous frame
    ready_mode = 2;
    got.delete(); fd_cnt = 0;
    feed(0, 36);
    drain("t2_count", 36);
    check_seq("t2_pix");
    chk("t2_frame_done", 32'(fd_cnt), 32'd1);
    chk("t2_overflow", 32'(err_overflow), 32'd0);

    // Overflow with consumer stalled
    ready_mode = 1;
    send_cfg(2, 1, 4);
    ready_mode = 0;
    got.delete(); fd_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, i, 1'b0);
      cyc(1'b0, 0, 1'b0);
      if (i == 7) chk("t3_no_ovf_yet", 32'(err_overflow), 32'd0);
      if (i == 8) chk("t3_ovf_set", 32'(err_overflow), 32'd1);
    end
    chk("t3_stall_valid", 32'(out_valid), 32'd1);
    chk("t3_stall_pixel", 32'(out_pixel), 32'd0);
    ready_mode = 1;
    for (int k = 0; k < 100 && got.size() < 8; k++) cyc(1'b0, 0, 1'b0);
    repeat (10) cyc(1'b0, 0, 1'b0);
    chk("t3_drain_count", 32'(got.size()), 32'd8);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    check_seq("t3_first8");
    feed(8, 8);
    drain("t3_total", 16);
    for (int i = 8; i < 16; i++) exp_q.push_back(i);
    check_seq("t3_all16");
    chk("t3_frame_done", 32'(fd_cnt), 32'd1);
    chk("t3_ovf_sticky", 32'(err_overflow), 32'd1);

    // Config pulse mid-frame is ignored
    send_cfg(3, 2, 2);
    got.delete(); fd_cnt = 0;
    for (int i = 0; i < 36; i++) begin
      cyc(1'b1, i, 1'b0);
      cyc(1'b0, 0, 1'b0);
      if (i == 10) begin
        send_cfg(2, 2, 1);
        cm = 8'd3; cb = 8'd2; cr = 8'd2;
      end
    end
    drain("t5_count", 36);
    exp_q = {0,1,2,9,10,11, 3,4,5,12,13,14, 6,7,8,15,16,17,
             18,19,20,27,28,29, 21,22,23,30,31,32, 24,25,26,33,34,35};
    check_seq("t5_pix");
    chk("t5_frame_done", 32'(fd_cnt), 32'd1);
    chk("t5_cfg_err", 32'(cfg_err), 32'd0);

    // Asynchronous reset during the second strip's drain
    got.delete(); fd_cnt = 0;
    feed(0, 36);
    for (int k = 0; k < 100 && got.size() < 22; k++) cyc(1'b0, 0, 1'b0);
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_pixel", 32'(out_pixel), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(frame_done), 32'd0);
    chk("t6_rst_ovf", 32'(err_overflow), 32'd0);
    chk("t6_rst_cfg_err", 32'(cfg_err), 32'd0);
    hold_chk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got.delete(); fd_cnt = 0;
    feed(0, 4);
    repeat (4) cyc(1'b0, 0, 1'b0);
    chk("t6_unconf_busy", 32'(busy), 32'd0);
    chk("t6_unconf_out", 32'(got.size()), 32'd0);

    // Rejected config, then a valid 4x2 frame
    send_cfg(80, 2, 1);
    chk("t4_cfg_err_set", 32'(cfg_err), 32'd1);
    feed(0, 4);
    repeat (4) cyc(1'b0, 0, 1'b0);
    chk("t4_bad_busy", 32'(busy), 32'd0);
    chk("t4_bad_out", 32'(got.size()), 32'd0);
    send_cfg(2, 2, 1);
    chk("t4_cfg_err_clr", 32'(cfg_err), 32'd0);
    got.delete(); fd_cnt = 0;
    feed(0, 8);
    drain("t4_count", 8);
    exp_q = {0,1,4,5,2,3,6,7};
    check_seq("t4_pix");
    chk("t4_frame_done", 32'(fd_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/block_reassembler.md
Name: block_reassembler

Overview:
- Downstream of the watermark block processor; consumes its per-pixel output stream (one-cycle pixel strobe, block-raster order, M*M pixels per block).
- Reassembles blocks into full image rows in a ping-pong strip buffer.
- Emits the watermarked image in image-raster order over a valid/ready interface to the image writer.
- Upstream has no backpressure, so the block buffers one full block-row strip while the previous strip drains.

Parameters:
DATA_DEPTH, 8, pixel width in bits
MAX_M, 72, largest supported block side M
MAX_WIDTH, 720, largest supported image width in pixels; each bank holds MAX_M*MAX_WIDTH pixels

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
cfg_valid  in  1  one-cycle strobe; latches cfg_* fields
cfg_m  in  8  block side M
cfg_bpr  in  8  blocks per block-row; image width W = M*cfg_bpr
cfg_rows  in  8  block-rows per frame
cfg_err  out  1  sticky; set when a configuration is rejected
pix_in  in  DATA_DEPTH  watermarked pixel from the upstream block processor
pix_valid  in  1  one-cycle strobe per pixel
out_pixel  out  DATA_DEPTH  raster-order output pixel
out_valid  out  1  out_pixel is valid
out_ready  in  1  consumer accepts out_pixel
busy  out  1  a frame is in progress (any fill or drain active)
frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted
err_overflow  out  1  sticky; a pixel arrived with no free bank

Behaviour:
- Reset: all outputs 0. Both banks empty, unconfigured. Counters 0. Write FSM in W_IDLE, read FSM in R_IDLE. Reset mid-frame discards all buffered data.
- Config acceptance:
  - cfg_valid is accepted only when busy=0; otherwise it is ignored.
  - Rejected if M==0, cfg_bpr==0, cfg_rows==0, M>MAX_M, or M*cfg_bpr>MAX_WIDTH. On rejection, cfg_err=1 and the block stays unconfigured.
  - A valid config clears cfg_err and is retained across frames until the next accepted cfg_valid.
- Write FSM:
  - W_IDLE: on pix_valid while configured, enter W_FILL, busy=1, and write the first pixel.
  - W_FILL: track counters c (0..M-1), r (0..M-1), bc (0..cfg_bpr-1) and br (0..cfg_rows-1).
  - Address = r*W + bc*M + c, maintained incrementally with adders only (no divide or modulo).
  - Per accepted pixel: c++. On c wrap: r++. On r wrap: bc++ and r=0. On bc wrap: the bank is full; mark it ready for drain, toggle the write bank, br++.
  - After the last pixel of the last block-row, return to W_IDLE.
- Pixels arriving while unconfigured are dropped; err_overflow is unaffected.
- Overflow: if a bank becomes full and the other bank is still ready or draining, the next pix_valid sets err_overflow and the pixel is dropped. Counters do not advance until a bank frees.
- Read FSM:
  - R_IDLE -> R_DRAIN when a bank is ready.
  - R_DRAIN reads linear addresses 0..M*W-1 in order through a synchronous RAM with registered output.
  - First out_valid no later than 2 cycles after the bank-full event.
  - out_pixel and out_valid hold stable while out_valid=1 and out_ready=0. One pixel per cycle when out_ready is held high.
  - After the last address is accepted, the bank is freed and the FSM goes to R_IDLE, or straight into the next ready bank with no bubble beyond the RAM latency.
- Frame end: when the final pixel of the final strip is accepted (out_valid&&out_ready), frame_done=1 on the next cycle for exactly one cycle. busy drops the same cycle.
- Simultaneous write and read on different banks is always legal. The same bank is never written and read at once.
- Arithmetic widths:
  - Address is ceil(log2(MAX_M*MAX_WIDTH)) bits.
  - W is computed once at config time into a 10-bit register.

Test Plan:
- Basic reassembly: cfg M=3, bpr=2, rows=2 (6x6). Feed pix_in=0..35, one per 2 cycles, out_ready=1. Output rows must be: 0,1,2,9,10,11 / 3,4,5,12,13,14 / 6,7,8,15,16,17 / then 18,19,20,27,28,29 ... ending with 24,25,26,33,34,35. frame_done pulses once, busy then =0.
- Backpressure: same stimulus, out_ready toggled 1/0 each cycle. Identical output sequence, with out_pixel held during every ready=0 cycle. No err_overflow.
- Overflow: M=2, bpr=1, rows=4, out_ready=0 throughout. The 9th pixel sets err_overflow and is dropped. Release out_ready: exactly 8 pixels out (values 0..7), then resume writing.
- Bad config: cfg M=80 -> cfg_err=1, pixels ignored. Then cfg M=2, bpr=2, rows=1 -> cfg_err=0, feed 0..7, output 0,1,4,5,2,3,6,7.
- Config while busy: cfg_valid mid-frame with different M is ignored and the frame completes with the original M.
- Reset mid-drain: assert rst during the strip-1 drain. All outputs go to 0 immediately, and the block requires a new cfg_valid before accepting pixels.
